otter_mmio_hub: RTL and testbench

Parametrised memory-mapped I/O hub between the OTTER MCU IOBUS and board peripherals. Replaces the hand-written fixed address decode with N read-only input channels and M write-only output registers, and adds a keyboard scancode FIFO with overflow tracking and a configurable interrupt generator, so bytes arriving faster than the ISR services them are not lost.

---
 rtl/otter_mmio_hub.sv | 197 +++++++++++++++++++
 tb/tb_otter_mmio_hub.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/otter_mmio_hub.sv
`default_nettype none
// ============================================================================
// Module   : otter_mmio_hub
// Purpose  : OTTER IOBUS MMIO hub with parametrised input/output channels,
//            keyboard scancode FIFO with sticky overflow and interrupt output.
// Revision : 1.0 - initial release
// ============================================================================
module otter_mmio_hub #(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0000,
    parameter logic [31:0] STRIDE     = 32'h20,
    parameter int          IN_CH      = 2,
    parameter int          OUT_CH     = 2,
    parameter int          OUT_W      = 16,
    parameter logic [31:0] KBD_OFS    = 32'h100,
    parameter int          FIFO_AW    = 3,
    parameter int          INTR_MODE  = 0,
    parameter int          INTR_PULSE = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [31:0]             IOBUS_ADDR,
    input  logic [31:0]             IOBUS_OUT,
    input  logic                    IOBUS_WR,
    output logic [31:0]             IOBUS_IN,
    input  logic [IN_CH*32-1:0]     IN_DATA,
    output logic [OUT_CH*OUT_W-1:0] OUT_DATA,
    input  logic [7:0]              KBD_SCANCODE,
    input  logic                    KBD_VALID,
    output logic                    INTR
);

    localparam int                 c_DEPTH    = 1 << FIFO_AW;
    localparam int                 c_PCW      = $clog2(INTR_PULSE + 1);
    localparam logic [31:0]        c_KBD_ADDR = BASE_ADDR + KBD_OFS;
    localparam logic [FIFO_AW:0]   c_FULL     = (FIFO_AW + 1)'(c_DEPTH);
    localparam logic [c_PCW-1:0]   c_PULSE    = c_PCW'(INTR_PULSE);

    logic [IN_CH-1:0]   w_in_hit;
    logic               w_kbd_hit;
    logic [31:0]        w_rdata;
    logic [31:0]        w_status;

    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic [FIFO_AW:0]   w_count_nxt;
    logic               r_ovf;

    logic               w_kbd_wr;
    logic               w_pop_req;
    logic               w_ovf_clr;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [7:0]         w_head;

    // ------------------------------------------------------------------
    // Read decode
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < IN_CH; gi++) begin : g_in_hit
            localparam logic [31:0] c_ADDR = 32'(BASE_ADDR + STRIDE * gi);
            assign w_in_hit[gi] = (IOBUS_ADDR == c_ADDR);
        end
    endgenerate

    assign w_kbd_hit = (IOBUS_ADDR == c_KBD_ADDR);

    always_comb begin
        w_rdata = 32'h0;
        for (int i = 0; i < IN_CH; i++) begin
            if (w_in_hit[i]) begin
                w_rdata = IN_DATA[32*i +: 32];
            end
        end
        if (w_kbd_hit) begin
            w_rdata = w_status;
        end
    end

    assign IOBUS_IN = w_rdata;

    // ------------------------------------------------------------------
    // Output registers; output j lives one stride above input j
    // ------------------------------------------------------------------
    genvar gj;
    generate
        for (gj = 0; gj < OUT_CH; gj++) begin : g_out_reg
            localparam logic [31:0] c_ADDR = 32'(BASE_ADDR + STRIDE * (gj + 1));
            logic [OUT_W-1:0] r_out;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_out <= '0;
                end else if (IOBUS_WR && (IOBUS_ADDR == c_ADDR)) begin
                    r_out <= IOBUS_OUT[OUT_W-1:0];
                end
            end

            assign OUT_DATA[OUT_W*gj +: OUT_W] = r_out;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Keyboard FIFO
    // ------------------------------------------------------------------
    assign w_kbd_wr  = IOBUS_WR && w_kbd_hit;
    assign w_pop_req = w_kbd_wr && IOBUS_OUT[0];
    assign w_ovf_clr = w_kbd_wr && IOBUS_OUT[1];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);

    // A pop on a full FIFO frees the slot the same-cycle push needs
    assign w_pop  = w_pop_req && !w_empty;
    assign w_push = KBD_VALID && (!w_full || w_pop);
    assign w_drop = KBD_VALID && w_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= KBD_SCANCODE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            // Set takes priority over a simultaneous clear
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign w_head   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign w_status = {8'h00, 8'(r_count), 6'h00, r_ovf, !w_empty, w_head};

    // ------------------------------------------------------------------
    // Interrupt generation
    // ------------------------------------------------------------------
    generate
        if (INTR_MODE == 0) begin : g_intr_pulse
            logic [c_PCW-1:0] r_pulse;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_pulse <= '0;
                end else if (w_push) begin
                    r_pulse <= c_PULSE;
                end else if (r_pulse != '0) begin
                    r_pulse <= r_pulse - 1'b1;
                end
            end

            assign INTR = (r_pulse != '0);
        end else begin : g_intr_level
            logic r_level;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_level <= 1'b0;
                end else begin
                    r_level <= (w_count_nxt != '0);
                end
            end

            assign INTR = r_level;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_otter_mmio_hub.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_mmio_hub
// Purpose  : Directed bench for otter_mmio_hub (pulse and level interrupt
//            variants) against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otter_mmio_hub;

    localparam logic [31:0] c_BASE = 32'h1100_0000;
    localparam logic [31:0] c_KBD  = 32'h1100_0100;
    localparam int          c_PW   = 2;
    localparam int          c_DEP  = 8;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT = '0;
    logic        IOBUS_WR = 1'b0;
    logic [63:0] IN_DATA = '0;
    logic [7:0]  KBD_SCANCODE = '0;
    logic        KBD_VALID = 1'b0;

    logic [31:0] rd0, rd1;
    logic [31:0] out0, out1;
    logic        intr0, intr1;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    otter_mmio_hub #(.INTR_MODE(0), .INTR_PULSE(c_PW)) dut0 (
        .CLK(CLK), .RESET(RESET), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .IOBUS_IN(rd0), .IN_DATA(IN_DATA), .OUT_DATA(out0),
        .KBD_SCANCODE(KBD_SCANCODE), .KBD_VALID(KBD_VALID), .INTR(intr0)
    );

    otter_mmio_hub #(.INTR_MODE(1), .INTR_PULSE(c_PW)) dut1 (
        .CLK(CLK), .RESET(RESET), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .IOBUS_IN(rd1), .IN_DATA(IN_DATA), .OUT_DATA(out1),
        .KBD_SCANCODE(KBD_SCANCODE), .KBD_VALID(KBD_VALID), .INTR(intr1)
    );

    // Reference model state
    logic [7:0]  q[$];
    logic        m_ovf = 1'b0;
    logic [15:0] m_out[2];
    int          cyc = 0;
    int          last_push = 0;
    logic        pulse_seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 2; i++) begin
            if (a == c_BASE + 32'h20 * i) r = IN_DATA[32*i +: 32];
        end
        if (a == c_KBD) begin
            r = {8'h00, 8'(q.size()), 6'h00, m_ovf, q.size() != 0,
                 (q.size() != 0) ? q[0] : 8'h00};
        end
        return r;
    endfunction

    // Model: advance on every rising edge from the inputs held at that edge
    initial begin
        m_out[0] = '0;
        m_out[1] = '0;
        forever begin
            @(posedge CLK);
            cyc++;
            if (RESET) begin
                q.delete();
                m_ovf = 1'b0;
                m_out[0] = '0;
                m_out[1] = '0;
                pulse_seen = 1'b0;
            end else begin
                logic kw, popped;
                kw = IOBUS_WR && (IOBUS_ADDR == c_KBD);
                popped = kw && IOBUS_OUT[0] && (q.size() != 0);
                if (popped) void'(q.pop_front());
                if (KBD_VALID) begin
                    if (q.size() < c_DEP) begin
                        q.push_back(KBD_SCANCODE);
                        last_push = cyc;
                        pulse_seen = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (kw && IOBUS_OUT[1] && !(KBD_VALID && !popped && q.size() == c_DEP && m_ovf))
                    m_ovf = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    if (IOBUS_WR && IOBUS_ADDR == c_BASE + 32'h20 * (j + 1))
                        m_out[j] = IOBUS_OUT[15:0];
                end
            end
        end
    end

    // Compare every cycle on the falling edge
    initial begin
        forever begin
            @(negedge CLK);
            chk("rd0", rd0, exp_rd(IOBUS_ADDR));
            chk("rd1", rd1, exp_rd(IOBUS_ADDR));
            chk("out0", out0, {m_out[1], m_out[0]});
            chk("out1", out1, {m_out[1], m_out[0]});
            chk("intr0", {31'h0, intr0}, {31'h0, pulse_seen && (cyc - last_push) < c_PW});
            chk("intr1", {31'h0, intr1}, {31'h0, q.size() != 0});
        end
    end

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic v, input logic [7:0] b, input logic r);
        #1;
        IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = w;
        KBD_VALID = v; KBD_SCANCODE = b; RESET = r;
        @(negedge CLK);
    endtask

    task automatic idle(input logic [31:0] a);
        step(a, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic push(input logic [7:0] b);
        step(c_KBD, 32'h0, 1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic pop();
        step(c_KBD, 32'h1, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        // Reset state
        step(c_KBD, 32'h0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("rst_out", out0, 32'h0);
        chk("rst_intr0", {31'h0, intr0}, 32'h0);
        chk("rst_stat", rd0, 32'h0);
        idle(c_BASE + 32'h300);

        // Output registers
        step(c_BASE + 32'h20, 32'h0000_BEEF, 1'b1, 1'b0, 8'h00, 1'b0);
        step(c_BASE + 32'h40, 32'hFFFF_1234, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("out_regs", out0, 32'h1234_BEEF);
        idle(c_BASE + 32'h20);
        chk("rd_outaddr", rd0, 32'h0);

        // Input channels and unmapped read
        #1 IN_DATA = {32'hA5A5_0001, 32'hDEAD_BEEF};
        idle(c_BASE + 32'h20);
        chk("rd_in1", rd0, 32'hA5A5_0001);
        idle(c_BASE);
        chk("rd_in0", rd0, 32'hDEAD_BEEF);
        idle(c_BASE + 32'h300);
        chk("rd_unmapped", rd0, 32'h0);

        // Basic FIFO
        push(8'h1C);
        chk("push_intr0", {31'h0, intr0}, 32'h1);
        chk("push_intr1", {31'h0, intr1}, 32'h1);
        push(8'h32);
        push(8'h21);
        idle(c_KBD);
        chk("stat3", rd0, 32'h0003_011C);
        pop(); pop();
        chk("stat1", rd0, 32'h0001_0121);
        pop(); pop();
        chk("stat_empty", rd0, 32'h0);
        chk("lvl_drop", {31'h0, intr1}, 32'h0);

        // Pulse width
        idle(c_KBD); idle(c_KBD); idle(c_KBD);
        push(8'h55);
        chk("pulse_c1", {31'h0, intr0}, 32'h1);
        idle(c_KBD);
        chk("pulse_c2", {31'h0, intr0}, 32'h1);
        idle(c_KBD);
        chk("pulse_c3", {31'h0, intr0}, 32'h0);
        pop();

        // Overflow
        for (int k = 0; k < 8; k++) push(8'(8'h10 + k));
        idle(c_KBD); idle(c_KBD); idle(c_KBD);
        push(8'h18);
        chk("drop_nopulse", {31'h0, intr0}, 32'h0);
        chk("stat_full", rd0, 32'h0008_0310);
        step(c_KBD, 32'h1, 1'b1, 1'b1, 8'h77, 1'b0);
        chk("full_pushpop", rd0, 32'h0008_0311);
        chk("full_pp_intr", {31'h0, intr0}, 32'h1);
        step(c_KBD, 32'h2, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("ovf_clr", rd0, 32'h0008_0111);
        step(c_KBD, 32'h2, 1'b1, 1'b1, 8'h99, 1'b0);
        chk("ovf_setwins", rd0, 32'h0008_0311);
        step(c_KBD, 32'h2, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 7; k++) pop();
        chk("tail_byte", rd0, 32'h0001_0177);
        pop();

        // Push and pop on empty
        step(c_KBD, 32'h1, 1'b1, 1'b1, 8'hAB, 1'b0);
        chk("empty_pushpop", rd0, 32'h0001_01AB);
        push(8'hC1); push(8'hC2); push(8'hC3);
        chk("stat4", rd0, 32'h0004_01AB);

        // Reset mid-operation
        step(c_KBD, 32'h0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("mid_rst_stat", rd0, 32'h0);
        chk("mid_rst_intr0", {31'h0, intr0}, 32'h0);
        chk("mid_rst_intr1", {31'h0, intr1}, 32'h0);
        chk("mid_rst_out", out0, 32'h0);
        idle(c_KBD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
